// File: rtl/uart_tx_scheduler.sv
// -----------------------------------------------------------------------------
// uart_tx_scheduler
//
// Transmit-side controller for a UART PISO shift register. Bytes written by the
// register interface are buffered in a small circular FIFO. One frame at a time
// is popped and presented to the PISO together with its parity bit, and the
// PISO send / active_flag / done_flag handshake is sequenced. The PISO status
// flags come from the baud-clock domain and are synchronised here.
//
// Parameters
//   FIFO_DEPTH   byte-FIFO entries (power of two, >= 2)
//   ACK_TIMEOUT  system clocks to wait for active_flag after send rises
//
// Ports
//   clk_i           system clock, rising edge
//   rst_i           asynchronous active-high reset, clears all state
//   wr_en_i         push wr_data_i into the FIFO this cycle
//   wr_data_i       byte to transmit
//   parity_type_i   00 none, 01 odd, 10 even, 11 none (sampled in LOAD only)
//   tx_enable_i     allows new frames to start
//   active_flag_i   PISO frame in progress (baud domain, asynchronous)
//   done_flag_i     PISO frame complete (baud domain, asynchronous)
//   send_o          frame request to PISO
//   data_in_o       byte presented to PISO (held until the next LOAD)
//   parity_bit_o    parity presented to PISO (held until the next LOAD)
//   fifo_count_o    entries held in the FIFO
//   fifo_full_o     FIFO holds FIFO_DEPTH entries
//   fifo_empty_o    FIFO holds no entries
//   busy_o          FSM not in IDLE
//   tx_done_o       one-cycle pulse per completed frame
//   overflow_o      one-cycle pulse when a write is dropped
//   timeout_err_o   one-cycle pulse when the PISO never acknowledged send
// -----------------------------------------------------------------------------
module uart_tx_scheduler #(
  parameter int FIFO_DEPTH  = 4,
  parameter int ACK_TIMEOUT = 65535
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        wr_en_i,
  input  logic [7:0]                  wr_data_i,
  input  logic [1:0]                  parity_type_i,
  input  logic                        tx_enable_i,
  input  logic                        active_flag_i,
  input  logic                        done_flag_i,
  output logic                        send_o,
  output logic [7:0]                  data_in_o,
  output logic                        parity_bit_o,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count_o,
  output logic                        fifo_full_o,
  output logic                        fifo_empty_o,
  output logic                        busy_o,
  output logic                        tx_done_o,
  output logic                        overflow_o,
  output logic                        timeout_err_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  // The timeout counter only has to reach ACK_TIMEOUT-1 before it fires.
  localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);
  localparam logic [TW-1:0] TMO_ONE  = TW'(1);
  localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_SEND      = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_DONE      = 3'd4
  } state_t;

  // Parity bit for a byte under the selected parity type.
  function automatic logic parity_calc(input logic [7:0] data, input logic [1:0] ptype);
    logic p;
    case (ptype)
      2'b01:   p = ~^data;
      2'b10:   p = ^data;
      default: p = 1'b1;
    endcase
    return p;
  endfunction

  // FSM
  state_t           state_q, state_d;
  logic [TW-1:0]    tmo_cnt_q, tmo_cnt_d;
  logic             timeout_d;

  // FIFO storage and bookkeeping
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, empty_q;
  logic             push_s, pop_s, drop_s;

  // Synchronisers for the baud-domain flags
  logic             act_s1_q, act_s2_q;
  logic             done_s1_q, done_s2_q, done_prev_q;
  logic             done_rise_s;

  // Registered outputs
  logic             send_q, busy_q, tx_done_q, overflow_q, timeout_q;
  logic [7:0]       data_q;
  logic             parity_q;

  assign done_rise_s = done_s2_q & ~done_prev_q;

  // Two-flop synchronisers plus the history flop for done rise detection.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      act_s1_q    <= 1'b0;
      act_s2_q    <= 1'b0;
      done_s1_q   <= 1'b0;
      done_s2_q   <= 1'b0;
      done_prev_q <= 1'b0;
    end else begin
      act_s1_q    <= active_flag_i;
      act_s2_q    <= act_s1_q;
      done_s1_q   <= done_flag_i;
      done_s2_q   <= done_s1_q;
      done_prev_q <= done_s2_q;
    end
  end

  // FIFO push/pop decisions and next pointer/count values.
  always_comb begin
    // The FSM pops only in LOAD, which it enters only when the FIFO is
    // non-empty, so a write into an empty FIFO is never popped the same cycle.
    pop_s    = (state_q == ST_LOAD);
    // A concurrent pop frees a slot, so a write when full is still accepted.
    push_s   = wr_en_i & (~full_q | pop_s);
    drop_s   = wr_en_i & full_q & ~pop_s;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // FIFO storage, pointers, count and status flags.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (push_s) begin
        mem_q[wr_ptr_q] <= wr_data_i;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == CNT_FULL);
      empty_q  <= (count_d == {CW{1'b0}});
    end
  end

  // Next-state logic for the frame sequencer.
  always_comb begin
    state_d   = state_q;
    tmo_cnt_d = tmo_cnt_q;
    timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty_q && tx_enable_i) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        tmo_cnt_d = {TW{1'b0}};
        state_d   = ST_SEND;
      end
      ST_SEND: begin
        // The counter holds the number of completed SEND cycles, so the
        // abort fires on the ACK_TIMEOUT-th edge after send rose.
        if (act_s2_q) begin
          state_d = ST_WAIT_DONE;
        end else if (tmo_cnt_q == TMO_LAST) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_ONE;
        end
      end
      ST_WAIT_DONE: begin
        if (done_rise_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_WAIT_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state and timeout counter registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      tmo_cnt_q <= {TW{1'b0}};
    end else begin
      state_q   <= state_d;
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  // Output registers; decoded from the next state so they align with it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      send_q     <= 1'b0;
      busy_q     <= 1'b0;
      tx_done_q  <= 1'b0;
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
      data_q     <= 8'h00;
      parity_q   <= 1'b1;
    end else begin
      send_q     <= (state_d == ST_SEND);
      busy_q     <= (state_d != ST_IDLE);
      tx_done_q  <= (state_d == ST_DONE);
      overflow_q <= drop_s;
      timeout_q  <= timeout_d;
      // Head byte and its parity are captured on the popping edge and then
      // held, so later parity_type changes cannot touch the current frame.
      if (pop_s) begin
        data_q   <= mem_q[rd_ptr_q];
        parity_q <= parity_calc(mem_q[rd_ptr_q], parity_type_i);
      end
    end
  end

  assign send_o        = send_q;
  assign data_in_o     = data_q;
  assign parity_bit_o  = parity_q;
  assign fifo_count_o  = count_q;
  assign fifo_full_o   = full_q;
  assign fifo_empty_o  = empty_q;
  assign busy_o        = busy_q;
  assign tx_done_o     = tx_done_q;
  assign overflow_o    = overflow_q;
  assign timeout_err_o = timeout_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_scheduler
//
// Bench for uart_tx_scheduler. A queue-based scoreboard tracks the FIFO
// contents from the write/pop rules and checks every frame's byte and parity;
// a small PISO model answers the send handshake. Directed sequences cover the
// timing relations and the full/overflow/timeout/reset cases, and a random
// phase mixes writes, parity changes and tx_enable toggling.
// -----------------------------------------------------------------------------
module tb_uart_tx_scheduler;

  localparam int DEPTH = 4;
  localparam int TMO   = 16;
  localparam int ACT_DLY  = 3;
  localparam int DONE_DLY = 40;
  localparam logic [18:0] RESET_VEC = {1'b0, 8'h00, 1'b1, 3'd0, 1'b0, 1'b1,
                                       1'b0, 1'b0, 1'b0, 1'b0};

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic [1:0] ptype = 2'b00;
  logic       tx_en = 1'b0;
  logic       active_flag, done_flag;
  logic       piso_en = 1'b1;

  logic       send_o, parity_bit_o, fifo_full_o, fifo_empty_o, busy_o;
  logic       tx_done_o, overflow_o, timeout_err_o;
  logic [7:0] data_in_o;
  logic [2:0] fifo_count_o;

  int n_checks = 0;
  int n_errors = 0;
  int tx_done_cnt = 0;
  int tmo_cnt = 0;

  uart_tx_scheduler #(.FIFO_DEPTH(DEPTH), .ACK_TIMEOUT(TMO)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .wr_en_i       (wr_en),
    .wr_data_i     (wr_data),
    .parity_type_i (ptype),
    .tx_enable_i   (tx_en),
    .active_flag_i (active_flag),
    .done_flag_i   (done_flag),
    .send_o        (send_o),
    .data_in_o     (data_in_o),
    .parity_bit_o  (parity_bit_o),
    .fifo_count_o  (fifo_count_o),
    .fifo_full_o   (fifo_full_o),
    .fifo_empty_o  (fifo_empty_o),
    .busy_o        (busy_o),
    .tx_done_o     (tx_done_o),
    .overflow_o    (overflow_o),
    .timeout_err_o (timeout_err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Parity from the count of ones: odd parity makes the total odd, even makes it even.
  function automatic logic ref_parity(input logic [7:0] b, input logic [1:0] t);
    int ones;
    ones = $countones(b);
    if (t == 2'b01)      return (ones % 2) == 0;
    else if (t == 2'b10) return (ones % 2) == 1;
    else                 return 1'b1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] b);
    wr_en = 1'b1;
    wr_data = b;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_send_rise(input string tag);
    int c;
    c = 0;
    while (!send_o && c < 100) begin tick(); c++; end
    check(tag, send_o, 1'b1);
  endtask

  task automatic wait_tx_done(input int target, input int budget);
    int c;
    c = 0;
    while (tx_done_cnt < target && c < budget) begin tick(); c++; end
    check("tx_done_count", tx_done_cnt, target);
  endtask

  task automatic wait_idle(input int budget);
    int c;
    c = 0;
    while ((!fifo_empty_o || busy_o) && c < budget) begin tick(); c++; end
    check("drain_idle", {fifo_empty_o, busy_o}, 2'b10);
  endtask

  // PISO model: active ACT_DLY clocks after seeing send, done pulse at DONE_DLY.
  initial begin
    int t;
    bit run;
    active_flag = 1'b0;
    done_flag = 1'b0;
    run = 1'b0;
    t = 0;
    forever begin
      @(posedge clk);
      #2;
      if (rst || !piso_en) begin
        active_flag = 1'b0;
        done_flag = 1'b0;
        run = 1'b0;
      end else if (!run) begin
        done_flag = 1'b0;
        if (send_o) begin
          run = 1'b1;
          t = 0;
        end
      end else begin
        t++;
        if (t == ACT_DLY) active_flag = 1'b1;
        if (t == DONE_DLY) begin
          active_flag = 1'b0;
          done_flag = 1'b1;
          run = 1'b0;
        end
      end
    end
  end

  // Inputs as seen by the DUT at each rising edge.
  logic       wr_seen = 1'b0;
  logic [7:0] wd_seen = 8'h00;
  logic [1:0] pt_seen = 2'b00;
  always @(posedge clk) begin
    wr_seen <= wr_en & ~rst;
    wd_seen <= wr_data;
    pt_seen <= ptype;
  end

  // Scoreboard: the FIFO as a queue, popped on each send rise, pushed on accepted writes.
  logic [7:0] model_q[$];
  logic       send_prev = 1'b0, tx_prev = 1'b0;
  logic [7:0] last_data = 8'h00;
  logic       last_par = 1'b1;
  always @(negedge clk) begin
    logic [7:0] b;
    logic       exp_ovf;
    if (rst) begin
      model_q.delete();
      send_prev = 1'b0;
      tx_prev = 1'b0;
      last_data = 8'h00;
      last_par = 1'b1;
      check("reset_outputs", {send_o, data_in_o, parity_bit_o, fifo_count_o, fifo_full_o,
                              fifo_empty_o, busy_o, tx_done_o, overflow_o, timeout_err_o},
            RESET_VEC);
    end else begin
      exp_ovf = 1'b0;
      if (send_o && !send_prev) begin
        check("send_with_data", model_q.size() != 0, 1'b1);
        if (model_q.size() != 0) begin
          b = model_q.pop_front();
          last_data = b;
          last_par = ref_parity(b, pt_seen);
          check("frame_data", data_in_o, b);
          check("frame_parity", parity_bit_o, last_par);
        end
      end else begin
        check("data_hold", {data_in_o, parity_bit_o}, {last_data, last_par});
      end
      if (wr_seen) begin
        if (model_q.size() < DEPTH) model_q.push_back(wd_seen);
        else exp_ovf = 1'b1;
      end
      check("overflow", overflow_o, exp_ovf);
      check("fifo_count", fifo_count_o, model_q.size());
      check("fifo_flags", {fifo_full_o, fifo_empty_o},
            {model_q.size() == DEPTH, model_q.size() == 0});
      if (tx_done_o) begin
        check("tx_done_width", tx_prev, 1'b0);
        tx_done_cnt++;
      end
      if (timeout_err_o) tmo_cnt++;
      send_prev = send_o;
      tx_prev = tx_done_o;
    end
  end

  initial begin
    int n;
    int base;
    // Reset with random inputs.
    #1 rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'($urandom_range(0, 1));
      wr_data = 8'($urandom);
      ptype = 2'($urandom_range(0, 3));
      tx_en = 1'($urandom_range(0, 1));
      tick();
    end
    wr_en = 1'b0; tx_en = 1'b0; ptype = 2'b00;
    rst = 1'b0;
    tick();

    // Single frame, even parity, with handshake timing.
    ptype = 2'b10; tx_en = 1'b1;
    write_byte(8'h4A);
    n = 0;
    while (!send_o && n < 10) begin tick(); n++; end
    check("send_latency", n, 2);
    check("even_data", data_in_o, 8'h4A);
    check("even_parity", parity_bit_o, 1'b1);
    n = 0;
    while (!active_flag && n < 20) begin tick(); n++; end
    check("active_seen", active_flag, 1'b1);
    n = 1;
    while (send_o && n < 20) begin tick(); n++; end
    check("send_drop_window", (n >= 2 && n <= 3), 1'b1);
    n = 0;
    while (!done_flag && n < 60) begin tick(); n++; end
    check("done_seen", done_flag, 1'b1);
    n = 1;
    while (!tx_done_o && n < 10) begin tick(); n++; end
    check("tx_done_latency", (n >= 2 && n <= 3), 1'b1);
    tick();
    check("single_tx_done", tx_done_cnt, 1);
    check("single_count", fifo_count_o, 0);
    wait_idle(50);

    // Odd parity, with parity_type changed mid-frame; then none (11).
    ptype = 2'b01;
    write_byte(8'h4A);
    wait_send_rise("odd_send");
    check("odd_parity", parity_bit_o, 1'b0);
    ptype = 2'b10;
    wait_tx_done(2, 200);
    check("odd_parity_held", parity_bit_o, 1'b0);
    ptype = 2'b11;
    write_byte(8'h5A);
    wait_send_rise("none_send");
    check("none_parity", parity_bit_o, 1'b1);
    check("none_data", data_in_o, 8'h5A);
    wait_tx_done(3, 200);
    wait_idle(50);

    // Full and overflow with transmit disabled, then in-order drain.
    tx_en = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      wr_en = 1'b1;
      wr_data = 8'(i);
      tick();
      if (i == 4) check("full_after_4", fifo_full_o, 1'b1);
      if (i == 5) check("overflow_5th", overflow_o, 1'b1);
    end
    wr_en = 1'b0;
    check("count_full", fifo_count_o, 4);
    tx_en = 1'b1;
    n = 0;
    while (!tx_done_o && n < 200) begin tick(); n++; end
    check("first_burst_done", tx_done_o, 1'b1);
    n = 0;
    while (!send_o && n < 10) begin tick(); n++; end
    check("b2b_gap", n, 3);
    wait_tx_done(7, 400);
    wait_idle(50);

    // Write on the LOAD cycle with the FIFO full.
    tx_en = 1'b0;
    for (int i = 0; i < 4; i++) write_byte(8'($urandom));
    check("full_again", fifo_full_o, 1'b1);
    tx_en = 1'b1;
    tick();
    wr_en = 1'b1;
    wr_data = 8'($urandom);
    tick();
    wr_en = 1'b0;
    check("count_wr_pop", fifo_count_o, 4);
    check("no_ovf_wr_pop", overflow_o, 1'b0);
    wait_tx_done(12, 600);
    wait_idle(50);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      wr_en = ($urandom_range(0, 7) == 0);
      wr_data = 8'($urandom);
      if ($urandom_range(0, 15) == 0) ptype = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 31) == 0) tx_en = ~tx_en;
      tick();
    end
    wr_en = 1'b0;
    tx_en = 1'b1;
    wait_idle(3000);

    // Handshake timeout, then the next byte loads and completes.
    base = tx_done_cnt;
    piso_en = 1'b0;
    write_byte(8'($urandom));
    write_byte(8'($urandom));
    wait_send_rise("tmo_send");
    n = 0;
    while (!timeout_err_o && n < 40) begin tick(); n++; end
    check("timeout_latency", n, TMO);
    check("send_low_at_timeout", send_o, 1'b0);
    piso_en = 1'b1;
    n = 0;
    while (!send_o && n < 10) begin tick(); n++; end
    check("next_after_timeout", n, 2);
    wait_tx_done(base + 1, 200);
    check("timeout_pulses", tmo_cnt, 1);
    wait_idle(50);

    // Reset asserted while waiting for done.
    write_byte(8'($urandom));
    write_byte(8'($urandom));
    wait_send_rise("rst_send");
    n = 0;
    while (send_o && n < 20) begin tick(); n++; end
    check("in_wait_done", {send_o, busy_o}, 2'b01);
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("reset_async", {send_o, data_in_o, parity_bit_o, fifo_count_o, fifo_full_o,
                          fifo_empty_o, busy_o, tx_done_o, overflow_o, timeout_err_o},
          RESET_VEC);
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("no_frame_after_reset", {busy_o, send_o, fifo_count_o}, 5'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    n_errors++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule
